even_gen_check: RTL and testbench

- Registered even-parity generator and checker for a WIDTH-bit data word plus one received parity bit.
- Generator produces the parity bit that makes the total count of ones in {a, gen} even.
- Checker flags when the total count of ones in {a, b} is odd.
- Sits on a byte datapath between the framing logic and the error-status register; tracks a sticky error flag and an optional saturating error counter.

---
 rtl/even_gen_check_if.sv | 31 +++
 rtl/even_gen_check.sv | 90 +++++++++
 tb/tb_even_gen_check.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/even_gen_check_if.sv
`default_nettype none
// ============================================================================
// Module : even_gen_check_if
// Brief  : Sample/result bundle between framing logic and the parity block.
// Rev    : 1.0  initial release
// ============================================================================
interface even_gen_check_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic             b;
  logic             err_clr;
  logic             gen;
  logic             check;
  logic             out_valid;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, a, b, err_clr,
    input  gen, check, out_valid, err_sticky, err_count
  );

  modport slave (
    input  in_valid, a, b, err_clr,
    output gen, check, out_valid, err_sticky, err_count
  );
endinterface
`default_nettype wire

// File: rtl/even_gen_check.sv
`default_nettype none
// ============================================================================
// Module : even_gen_check
// Brief  : Registered even-parity generator/checker with sticky error flag.
//          Optional saturating error counter: EVEN_GEN_CHECK_ERR_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module even_gen_check #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  even_gen_check_if.slave  bus
);

  logic [WIDTH-1:0] a_w;
  logic             sample_err;
  logic             gen_q, gen_d;
  logic             check_q, check_d;
  logic             out_valid_q, out_valid_d;
  logic             err_sticky_q, err_sticky_d;

  assign a_w        = bus.a;
  // Gated by in_valid so X on idle inputs never reaches any flop.
  assign sample_err = bus.in_valid & (^{a_w, bus.b});

  always_comb begin
    gen_d        = gen_q;
    check_d      = check_q;
    out_valid_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    if (bus.in_valid) begin
      gen_d       = ^a_w;
      check_d     = ^{a_w, bus.b};
      out_valid_d = 1'b1;
    end
    if (sample_err) begin
      err_sticky_d = 1'b1;
    end else if (bus.err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_q        <= 1'b0;
      check_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      gen_q        <= gen_d;
      check_q      <= check_d;
      out_valid_q  <= out_valid_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.gen        = gen_q;
  assign bus.check      = check_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.err_sticky = err_sticky_q;

`ifdef EVEN_GEN_CHECK_ERR_CNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (bus.err_clr) begin
      err_count_d = sample_err ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (sample_err && !(&err_count_q)) begin
      err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= {CNT_W{1'b0}};
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_even_gen_check.sv
`default_nettype none
// ============================================================================
// Module : tb_even_gen_check
// Brief  : Directed self-checking bench for even_gen_check (CNT_W=2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_even_gen_check;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  even_gen_check_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  even_gen_check #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at negedge, return 1 time unit after posedge.
  task automatic step(input logic v, input logic [WIDTH-1:0] av, input logic bv,
                      input logic clr, input logic r);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
    bus.err_clr  = clr;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if ({bus.gen, bus.check, bus.out_valid, bus.err_sticky} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags got gen/chk/ov/stk=%b%b%b%b want 0000",
               bus.gen, bus.check, bus.out_valid, bus.err_sticky);
    end
    n_vec++;
    if (bus.err_count !== 2'd0) begin
      n_err++;
      $display("FAIL reset_count got %0d want 0", bus.err_count);
    end
  endtask

  task automatic test_generator();
    logic [7:0] av [5] = '{8'h00, 8'h01, 8'h02, 8'h1C, 8'hAA};
    logic       eg [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, av[i], 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({bus.gen, bus.check, bus.out_valid} !== {eg[i], eg[i], 1'b1}) begin
        n_err++;
        $display("FAIL gen_sweep a=%h got gen/chk/ov=%b%b%b want %b%b1",
                 av[i], bus.gen, bus.check, bus.out_valid, eg[i], eg[i]);
      end
    end
  endtask

  task automatic test_checker();
    logic [7:0] av [7] = '{8'h03, 8'h55, 8'hDB, 8'h1E, 8'hF0, 8'h6D, 8'h03};
    logic       bv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       eg [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       ec [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, av[i], bv[i], 1'b0, 1'b0);
      n_vec++;
      if ({bus.gen, bus.check, bus.out_valid} !== {eg[i], ec[i], 1'b1}) begin
        n_err++;
        $display("FAIL checker a=%h b=%b got gen/chk/ov=%b%b%b want %b%b1",
                 av[i], bv[i], bus.gen, bus.check, bus.out_valid, eg[i], ec[i]);
      end
    end
  endtask

  task automatic test_valid_gating();
    // Clean sample (gen=1, check=0) with a clear in the same cycle: sticky 0.
    step(1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      step(1'b0, 8'hxx, 1'bx, 1'b0, 1'b0);
      else if (i == 1) step(1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
      else             step(1'b0, 8'hFF ^ 8'(i), 1'(i), 1'b0, 1'b0);
      n_vec++;
      if ({bus.gen, bus.check, bus.out_valid, bus.err_sticky} !== 4'b1000) begin
        n_err++;
        $display("FAIL valid_gating cyc=%0d got gen/chk/ov/stk=%b%b%b%b want 1000",
                 i, bus.gen, bus.check, bus.out_valid, bus.err_sticky);
      end
    end
  endtask

  task automatic test_sticky();
    logic       vv [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] av [6] = '{8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h01};
    logic       cl [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       es [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(vv[i], av[i], 1'b0, cl[i], 1'b0);
      n_vec++;
      if (bus.err_sticky !== es[i]) begin
        n_err++;
        $display("FAIL sticky step=%0d got %b want %b", i, bus.err_sticky, es[i]);
      end
    end
  endtask

  task automatic test_counter();
    logic [1:0] exp_cnt;
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (bus.err_count !== 2'd0) begin
      n_err++;
      $display("FAIL count_clr0 got %0d want 0", bus.err_count);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
`ifdef EVEN_GEN_CHECK_ERR_CNT_EN
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
`else
      exp_cnt = 2'd0;
`endif
      n_vec++;
      if (bus.err_count !== exp_cnt) begin
        n_err++;
        $display("FAIL count_inc n=%0d got %0d want %0d", i + 1, bus.err_count, exp_cnt);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (bus.err_count !== 2'd0) begin
      n_err++;
      $display("FAIL count_clr got %0d want 0", bus.err_count);
    end
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
`ifdef EVEN_GEN_CHECK_ERR_CNT_EN
    exp_cnt = 2'd1;
`else
    exp_cnt = 2'd0;
`endif
    n_vec++;
    if (bus.err_count !== exp_cnt) begin
      n_err++;
      $display("FAIL count_clr_inc got %0d want %0d", bus.err_count, exp_cnt);
    end
  endtask

  task automatic test_midstream_reset();
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({bus.gen, bus.check, bus.out_valid, bus.err_sticky, bus.err_count} !== 6'b0) begin
      n_err++;
      $display("FAIL midstream_rst got gen/chk/ov/stk=%b%b%b%b cnt=%0d want 0000 cnt=0",
               bus.gen, bus.check, bus.out_valid, bus.err_sticky, bus.err_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_rst_ov got %b want 0", bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = 1'b0;
    bus.err_clr  = 1'b0;
    test_reset();
    test_generator();
    test_checker();
    test_valid_gating();
    test_sticky();
    test_counter();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
